// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache.
// The CPU side is a load/store port that stalls on `miss`. The memory side is a
// word-addressed synchronous RAM whose read data arrives one cycle after the address.
module dcache_wb #(
   parameter int LINE_ADDR_LEN = 3,
   parameter int SET_ADDR_LEN  = 2,
   parameter int TAG_ADDR_LEN  = 6,
   parameter int MEM_ADDR_LEN  = 11
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rd_req,
   input  logic                    wr_req,
   input  logic [31:0]             addr,
   input  logic [31:0]             wr_data,
   output logic [31:0]             rd_data,
   output logic                    miss,
   output logic [MEM_ADDR_LEN-1:0] mem_addr,
   output logic                    mem_wr_req,
   output logic [31:0]             mem_wr_data,
   input  logic [31:0]             mem_rd_data,
   output logic [31:0]             hit_cnt,
   output logic [31:0]             miss_cnt
);

   localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
   localparam int SET_SIZE  = 1 << SET_ADDR_LEN;
   localparam int TAG_LO    = LINE_ADDR_LEN + SET_ADDR_LEN + 2;

   // Word counter needs one extra bit: the fill runs LINE_SIZE+1 cycles.
   localparam logic [LINE_ADDR_LEN:0] CNT_LAST = {1'b0, {LINE_ADDR_LEN{1'b1}}};
   localparam logic [LINE_ADDR_LEN:0] CNT_FULL = {1'b1, {LINE_ADDR_LEN{1'b0}}};

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SWAP_OUT   = 2'd1,
      SWAP_IN    = 2'd2,
      SWAP_IN_OK = 2'd3
   } state_t;

   state_t                   state_q, state_d;
   logic [LINE_ADDR_LEN:0]   cnt_q, cnt_d;
   logic [SET_SIZE-1:0]      valid_q, dirty_q;
   logic [31:0]              hit_cnt_q, miss_cnt_q;

   // Line storage and tags are left unreset; valid bits guard them.
   logic [31:0]              data_q [SET_SIZE*LINE_SIZE];
   logic [TAG_ADDR_LEN-1:0]  tag_q  [SET_SIZE];

   logic [LINE_ADDR_LEN-1:0] offset;
   logic [SET_ADDR_LEN-1:0]  set;
   logic [TAG_ADDR_LEN-1:0]  tag;
   logic                     req, is_rd, is_wr, hit, miss_idle;
   logic [LINE_ADDR_LEN:0]   fill_idx;
   logic                     unused_addr_bits;

   assign offset = addr[LINE_ADDR_LEN+1:2];
   assign set    = addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
   assign tag    = addr[TAG_LO+TAG_ADDR_LEN-1:TAG_LO];
   assign unused_addr_bits = ^{addr[31:TAG_LO+TAG_ADDR_LEN], addr[1:0]};

   // A simultaneous load and store is handled as a store.
   assign req   = rd_req | wr_req;
   assign is_wr = wr_req;
   assign is_rd = rd_req & ~wr_req;

   assign hit       = (state_q == IDLE) & req & valid_q[set] & (tag_q[set] == tag);
   assign miss_idle = (state_q == IDLE) & req & ~hit;
   assign miss      = (state_q != IDLE) | miss_idle;
   assign rd_data   = (hit & is_rd) ? data_q[{set, offset}] : 32'd0;
   assign fill_idx  = cnt_q - 1'b1;

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;

   // FSM state, word counter, line status bits and performance counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         valid_q    <= '0;
         dirty_q    <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (hit)
            hit_cnt_q <= hit_cnt_q + 32'd1;
         if (miss_idle)
            miss_cnt_q <= miss_cnt_q + 32'd1;
         if (hit & is_wr)
            dirty_q[set] <= 1'b1;
         if (state_q == SWAP_IN_OK) begin
            valid_q[set] <= 1'b1;
            dirty_q[set] <= 1'b0;
         end
      end
   end

   // Line data and tag writes: store hits, fill captures and the final tag update.
   always_ff @(posedge clk) begin
      if (hit & is_wr)
         data_q[{set, offset}] <= wr_data;
      if ((state_q == SWAP_IN) && (cnt_q != '0))
         data_q[{set, fill_idx[LINE_ADDR_LEN-1:0]}] <= mem_rd_data;
      if (state_q == SWAP_IN_OK)
         tag_q[set] <= tag;
   end

   // Next-state logic and memory-side drive for eviction and refill.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_wr_req  = 1'b0;
      mem_addr    = '0;
      mem_wr_data = '0;
      unique case (state_q)
         IDLE: begin
            if (miss_idle) begin
               cnt_d   = '0;
               state_d = (valid_q[set] & dirty_q[set]) ? SWAP_OUT : SWAP_IN;
            end
         end
         SWAP_OUT: begin
            mem_wr_req  = 1'b1;
            mem_addr    = {tag_q[set], set, cnt_q[LINE_ADDR_LEN-1:0]};
            mem_wr_data = data_q[{set, cnt_q[LINE_ADDR_LEN-1:0]}];
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = SWAP_IN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SWAP_IN: begin
            if (!cnt_q[LINE_ADDR_LEN])
               mem_addr = {tag, set, cnt_q[LINE_ADDR_LEN-1:0]};
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               state_d = SWAP_IN_OK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SWAP_IN_OK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU load/store port and the word-addressed synchronous memory.
- Acts as the initiator of the memory interface: drives address and write strobe, captures read data one cycle after issuing an address.
- Stalls the CPU through `miss` while it evicts dirty lines and fills lines.
- Exports hit/miss counters for performance measurement.

Parameters:
- LINE_ADDR_LEN, 3, log2 of words per line (LINE_SIZE = 8)
- SET_ADDR_LEN, 2, log2 of number of lines (4 sets)
- TAG_ADDR_LEN, 6, tag width
- MEM_ADDR_LEN, 11, memory word-address width; must equal LINE_ADDR_LEN+SET_ADDR_LEN+TAG_ADDR_LEN

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rd_req  in  1  CPU load request
- wr_req  in  1  CPU store request
- addr  in  32  CPU byte address; bits [1:0] ignored
- wr_data  in  32  store data
- rd_data  out  32  load data
- miss  out  1  stall; CPU holds rd_req, wr_req, addr and wr_data stable while high
- mem_addr  out  MEM_ADDR_LEN  memory word address
- mem_wr_req  out  1  memory write strobe
- mem_wr_data  out  32  memory write data
- mem_rd_data  in  32  memory read data; registered, valid the cycle after mem_addr is presented
- hit_cnt  out  32  completed hits
- miss_cnt  out  32  misses taken

Behaviour:
- Single clock, rst_n is asynchronous active-low.
- Reset (asynchronous, any state, including mid-transfer):
  - all valid/dirty bits cleared; FSM to IDLE; counters 0; partial write-back or fill abandoned.
  - mem_wr_req, mem_addr, mem_wr_data and rd_data go to 0 immediately.
  - Data/tag arrays are not reset.
- Address split: offset = addr[LINE_ADDR_LEN+1:2]; set = next SET_ADDR_LEN bits; tag = next TAG_ADDR_LEN bits; upper bits ignored.
- Request priority: rd_req and wr_req both high is treated as a write.
- hit = request & valid[set] & tag_match; miss = request & ~hit. Both combinational, only in IDLE; miss is forced to 1 in every non-IDLE state.
- FSM states:
  - IDLE:
    - read hit: rd_data = line word combinationally, same cycle; hit_cnt+1 at the clock edge.
    - write hit: word written and dirty set at the clock edge; hit_cnt+1; no memory traffic.
    - miss: miss_cnt+1; next state SWAP_OUT if the victim is valid & dirty, else SWAP_IN.
    - mem_wr_req = 0, mem_addr = 0.
  - SWAP_OUT:
    - LINE_SIZE cycles, i = 0..LINE_SIZE-1.
    - Drives mem_wr_req = 1, mem_addr = {old_tag, set, i}, mem_wr_data = line[i].
    - After i = LINE_SIZE-1, goes to SWAP_IN.
  - SWAP_IN:
    - LINE_SIZE+1 cycles. Cycle k (k < LINE_SIZE) drives mem_addr = {new_tag, set, k}, mem_wr_req = 0.
    - Cycle k >= 1 captures mem_rd_data into line[k-1].
    - Then goes to SWAP_IN_OK.
  - SWAP_IN_OK: 1 cycle; writes tag, valid = 1, dirty = 0; returns to IDLE. The held request then hits and completes, counted as a hit too.
- Latency, miss detected in cycle T:
  - clean miss: miss high T..T+LINE_SIZE+2 (11 cycles); request completes at T+LINE_SIZE+3.
  - dirty miss adds LINE_SIZE cycles (19 total).
- rd_data is 0 whenever there is no read hit.
- Counters wrap modulo 2^32.
- Requests asserted while miss is high but changing address are a protocol violation; behaviour undefined, bench asserts against it.
- Memory side never has mem_wr_req high outside SWAP_OUT.

Test Plan:
- Memory preloaded word i = 4*i+1. Cold read addr 0x04:
  - miss high 11 cycles; mem_addr 0..7 on consecutive cycles;
  - then rd_data = 0x05; miss_cnt = 1, hit_cnt = 1.
- Read 0x08 immediately after → hit same cycle, rd_data = 0x09, miss = 0, hit_cnt = 2, no memory traffic.
- Write 0x04 ← 0xDEADBEEF → completes same cycle, mem_wr_req stays 0; read 0x04 → 0xDEADBEEF.
- Read 0x80 (tag 1, set 0) after the dirty write:
  - mem_wr_req high 8 cycles, mem_addr 0..7, word 1 written = 0xDEADBEEF;
  - then fill mem_addr 32..39; miss high 19 cycles; rd_data = 0x81.
- rd_req = wr_req = 1 at addr 0x84, wr_data 0x1234 → treated as a write; subsequent read 0x84 = 0x1234, line dirty.
- Assert rst_n low during SWAP_OUT cycle 3:
  - mem_wr_req drops to 0 asynchronously; counters 0;
  - next read 0x04 takes a clean miss with no write-back traffic.
